mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer for the EX stage of the 5-stage MIPS pipeline; owns the HI/LO architectural registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and holds the operation busy for a fixed cycle count.
- Raises a stall request to the pipeline hazard logic while any HI/LO-using instruction sits in ID during a pending operation.

---
 rtl/mdu_ctrl_pkg.sv | 23 ++
 rtl/mdu_arith.sv | 68 ++++++
 rtl/mdu_ctrl.sv | 105 ++++++++++
 tb/tb_mdu_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// ============================================================================
// Module : mdu_ctrl_pkg
// Brief  : Shared encodings for the MDU sequencer and its arithmetic unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_ctrl_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// ============================================================================
// Module : mdu_arith
// Brief  : Combinational 64-bit multiply/divide result ({hi, lo}) for the MDU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [63:0] result
);

    // op[0]==0 selects the signed flavour for both MULT and DIV
    logic        w_signed;
    logic [63:0] w_mulA;
    logic [63:0] w_mulB;
    logic [63:0] w_prod;
    logic [31:0] w_absRs;
    logic [31:0] w_absRt;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_sQuo;
    logic [31:0] w_sRem;
    logic        w_divZero;
    logic        w_ovf;

    assign w_signed  = ~op[0];
    assign w_mulA    = {(w_signed ? {32{rs_val[31]}} : 32'd0), rs_val};
    assign w_mulB    = {(w_signed ? {32{rt_val[31]}} : 32'd0), rt_val};
    assign w_prod    = w_mulA * w_mulB;

    assign w_absRs   = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    assign w_absRt   = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
    assign w_dvd     = w_signed ? w_absRs : rs_val;
    assign w_dvs     = w_signed ? w_absRt : rt_val;
    assign w_divZero = (rt_val == 32'd0);
    assign w_quo     = w_divZero ? 32'd0 : (w_dvd / w_dvs);
    assign w_rem     = w_divZero ? 32'd0 : (w_dvd % w_dvs);
    assign w_sQuo    = (rs_val[31] ^ rt_val[31]) ? (~w_quo + 32'd1) : w_quo;
    assign w_sRem    = rs_val[31] ? (~w_rem + 32'd1) : w_rem;
    assign w_ovf     = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);

    always_comb begin
        result = 64'd0;
        case (op)
            MDU_MULT, MDU_MULTU: result = w_prod;
            MDU_DIV: begin
                if (w_divZero)  result = {rs_val, 32'hFFFF_FFFF};
                else if (w_ovf) result = {32'd0, 32'h8000_0000};
                else            result = {w_sRem, w_sQuo};
            end
            MDU_DIVU: begin
                if (w_divZero)  result = {rs_val, 32'hFFFF_FFFF};
                else            result = {w_rem, w_quo};
            end
            default: result = 64'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
// Module : mdu_ctrl
// Brief  : EX-stage multiply/divide sequencer owning HI/LO, with ID stall request.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hilo_use_d,
    output logic        busy,
    output logic        stall_mdu,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] C_MUL_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] C_DIV_LOAD = 4'(DIV_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_pendHi;
    logic [31:0] r_pendLo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic [63:0] w_result;

    mdu_arith u_arith (
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .result (w_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_pendHi <= 32'd0;
            r_pendLo <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            MDU_MULT, MDU_MULTU: begin
                                r_state  <= MUL;
                                r_cnt    <= C_MUL_LOAD;
                                r_pendHi <= w_result[63:32];
                                r_pendLo <= w_result[31:0];
                            end
                            MDU_DIV, MDU_DIVU: begin
                                r_state  <= DIV;
                                r_cnt    <= C_DIV_LOAD;
                                r_pendHi <= w_result[63:32];
                                r_pendLo <= w_result[31:0];
                            end
                            MDU_MTHI: r_hi <= rs_val;
                            MDU_MTLO: r_lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                // A start arriving here is a pipeline protocol violation and is dropped
                MUL, DIV: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_hi    <= r_pendHi;
                        r_lo    <= r_pendLo;
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    // Only mult/div in EX (op[2]==0) creates a same-cycle hazard; MTHI/MTLO never do
    assign stall_mdu = hilo_use_d & (busy | (start & ~op[2]));
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
// Module : tb_mdu_ctrl
// Brief  : Self-checking bench for mdu_ctrl using directed vectors and sequences.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hilo_use_d;
    logic        busy;
    logic        stall_mdu;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests;
    int fails;

    mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .hilo_use_d (hilo_use_d),
        .busy       (busy),
        .stall_mdu  (stall_mdu),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          cycles;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic hu);
        @(negedge clk);
        start      = 1'b1;
        op         = o;
        rs_val     = a;
        rt_val     = b;
        hilo_use_d = hu;
        #1;
    endtask

    initial begin
        int n;
        tests      = 0;
        fails      = 0;
        reset      = 1'b0;
        start      = 1'b0;
        op         = 3'b000;
        rs_val     = 32'd0;
        rt_val     = 32'd0;
        hilo_use_d = 1'b0;

        vecs[0] = '{3'b000, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1] = '{3'b001, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2] = '{3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{3'b011, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 10};
        vecs[4] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
        vecs[5] = '{3'b010, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 10};
        vecs[6] = '{3'b000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
        vecs[7] = '{3'b011, 32'd100,       32'd7,         32'd2,         32'd14,        10};
        vecs[8] = '{3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
        vecs[9] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         5};

        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b1;

        // MTHI / MTLO: immediate write, no busy, no done, never stall
        issue(3'b100, 32'h1234_5678, 32'd0, 1'b1);
        chk("mthi_stall", {31'd0, stall_mdu}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        hilo_use_d = 1'b0;
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_done", {31'd0, done}, 32'd0);
        issue(3'b101, 32'hCAFE_0001, 32'd0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", lo, 32'hCAFE_0001);
        chk("mtlo_hi_kept", hi, 32'h1234_5678);

        // Table-driven arithmetic and latency
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0);
            chk($sformatf("v%0d_busy_start", i), {31'd0, busy}, 32'd0);
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (busy && n < 40) begin
                n++;
                @(negedge clk);
            end
            chk($sformatf("v%0d_cycles", i), n, vecs[i].cycles);
            chk($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].expHi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].expLo);
            @(negedge clk);
            chk($sformatf("v%0d_done_drop", i), {31'd0, done}, 32'd0);
        end

        // Stall: MULT in EX with MFLO in ID
        issue(3'b000, 32'd2, 32'd3, 1'b1);
        chk("stall_start", {31'd0, stall_mdu}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            chk($sformatf("stall_busy%0d", n), {31'd0, stall_mdu}, 32'd1);
            @(negedge clk);
        end
        chk("stall_cycles", n, 32'd5);
        chk("stall_after", {31'd0, stall_mdu}, 32'd0);
        hilo_use_d = 1'b0;

        // No dependent instruction in ID: no stall at any point
        issue(3'b001, 32'd2, 32'd3, 1'b0);
        chk("nostall_start", {31'd0, stall_mdu}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (stall_mdu !== 1'b0) chk("nostall_busy", {31'd0, stall_mdu}, 32'd0);
            @(negedge clk);
        end
        chk("nostall_cycles", n, 32'd5);
        chk("nostall_lo", lo, 32'd6);

        // Start while busy must be ignored
        issue(3'b011, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            start  = (n == 2);
            op     = 3'b000;
            rs_val = 32'd5;
            rt_val = 32'd5;
            @(negedge clk);
        end
        start = 1'b0;
        chk("ignore_cycles", n, 32'd10);
        chk("ignore_hi", hi, 32'd2);
        chk("ignore_lo", lo, 32'd14);
        @(negedge clk);
        chk("ignore_no_restart", {31'd0, busy}, 32'd0);

        // Reset during DIV at cnt=4 (6th busy cycle)
        issue(3'b010, 32'd50, 32'd5, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstmid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || lo !== 32'd0) n++;
        end
        chk("rstmid_quiet", n, 32'd0);
        chk("rstmid_lo_final", lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
